// File: rtl/conv_pkg.sv
// Shared widths, FSM state encoding and saturation limits for the convolution writeback stage.
package conv_pkg;

  localparam int ACC_W      = 32;
  localparam int BIAS_W     = 18;
  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 16;
  localparam int CNT_W      = 16;
  localparam int FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } wb_state_t;

  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(32767);
  localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-32768);

  // Clamp a widened signed value into one memory word; lo selects signed or ReLU floor.
  function automatic logic [DATA_W-1:0] sat_to_word(input logic signed [ACC_W:0] v,
                                                    input logic signed [ACC_W:0] lo);
    if (v > SAT_MAX)
      return SAT_MAX[DATA_W-1:0];
    else if (v < lo)
      return lo[DATA_W-1:0];
    else
      return v[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/conv_wb_fifo.sv
// Small synchronous FIFO holding clamped results until the memory port grants them.
module conv_wb_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];
  assign w_pop   = i_pop && !o_empty;
  // A full FIFO may still take a push when the head leaves in the same cycle.
  assign w_push  = i_push && (!o_full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/conv_writeback.sv
// Bias, rescale, clamp and write accelerator sums to memory; wb_done marks the exact end of a run.
// Build option: define CONV_WB_RELU_EN to floor results at zero (ReLU fused with saturation).
module conv_writeback
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] output_memory_offset,
  input  logic [CNT_W-1:0]  output_count,
  input  logic [BIAS_W-1:0] filter_bias,
  input  logic [3:0]        out_shift,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ACC_W-1:0]  in_sum,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_grant,
  output logic              wb_done
);

  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

`ifdef CONV_WB_RELU_EN
  localparam logic signed [ACC_W:0] LOW_LIMIT = '0;
`else
  localparam logic signed [ACC_W:0] LOW_LIMIT = SAT_MIN;
`endif

  wb_state_t r_state;
  wb_state_t w_next_state;

  logic [ADDR_W-1:0]       r_offset;
  logic [CNT_W-1:0]        r_count;
  logic [CNT_W-1:0]        r_accepted;
  logic [BIAS_W-1:0]       r_bias;
  logic [3:0]              r_shift;
  logic [ADDR_W-1:0]       r_write_idx;
  logic                    r_s1_valid;
  logic signed [ACC_W:0]   r_s1;
  logic                    r_wb_done;

  logic                    w_start_ok;
  logic                    w_fire;
  logic                    w_pop;
  logic                    w_drained;
  logic signed [ACC_W:0]   w_s1_sum;
  logic signed [ACC_W:0]   w_shifted;
  logic [DATA_W-1:0]       w_clamped;
  logic [DATA_W-1:0]       w_fifo_head;
  logic [FCW-1:0]          w_fifo_count;
  logic                    w_fifo_full;
  logic                    w_fifo_empty;

  assign w_start_ok = start && (r_state == ST_IDLE || r_state == ST_DONE);

  // Credits count the stage-1 result still in flight so the FIFO can never overflow.
  assign in_ready = (r_state == ST_RUN) && (r_accepted < r_count) && !w_fifo_full &&
                    ((32'(w_fifo_count) + 32'(r_s1_valid)) < FIFO_DEPTH);
  assign w_fire   = in_valid && in_ready;

  assign w_s1_sum  = {in_sum[ACC_W-1], in_sum} +
                     {{(ACC_W+1-BIAS_W){r_bias[BIAS_W-1]}}, r_bias};
  assign w_shifted = r_s1 >>> r_shift;
  assign w_clamped = sat_to_word(w_shifted, LOW_LIMIT);

  assign mem_we    = !w_fifo_empty && (r_state == ST_RUN || r_state == ST_DRAIN);
  assign w_pop     = mem_we && mem_grant;
  assign mem_addr  = mem_we ? (r_offset + r_write_idx) : '0;
  assign mem_wdata = mem_we ? w_fifo_head : '0;
  assign wb_done   = r_wb_done;

  // Everything accepted and the last buffered word leaves this cycle (or already has).
  assign w_drained = (r_accepted == r_count) && !r_s1_valid &&
                     ((w_fifo_count == '0) || ((w_fifo_count == FCW'(1)) && w_pop));

  conv_wb_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (r_s1_valid),
    .i_data  (w_clamped),
    .i_pop   (w_pop),
    .o_data  (w_fifo_head),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (start) w_next_state = (output_count == '0) ? ST_DONE : ST_RUN;
      ST_RUN:           if (r_accepted == r_count) w_next_state = ST_DRAIN;
      ST_DRAIN:         if (w_drained) w_next_state = ST_DONE;
      default:          w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_wb_done   <= 1'b0;
      r_offset    <= '0;
      r_count     <= '0;
      r_accepted  <= '0;
      r_bias      <= '0;
      r_shift     <= '0;
      r_write_idx <= '0;
      r_s1_valid  <= 1'b0;
      r_s1        <= '0;
    end else begin
      r_state    <= w_next_state;
      r_wb_done  <= (w_next_state == ST_DONE);
      r_s1_valid <= w_fire;
      if (w_fire) r_s1 <= w_s1_sum;
      if (w_start_ok) begin
        r_offset    <= output_memory_offset;
        r_count     <= output_count;
        r_bias      <= filter_bias;
        r_shift     <= out_shift;
        r_accepted  <= '0;
        r_write_idx <= '0;
      end else begin
        if (w_fire) r_accepted <= r_accepted + 1'b1;
        if (w_pop)  r_write_idx <= r_write_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_conv_writeback.sv
// Bench for conv_writeback: directed and randomized runs scored against an arithmetic reference model.
module tb_conv_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] output_memory_offset;
  logic [15:0] output_count;
  logic [17:0] filter_bias;
  logic [3:0]  out_shift;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_sum;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_grant;
  logic        wb_done;

  conv_writeback dut (
    .clk                  (clk),
    .rst                  (rst),
    .start                (start),
    .output_memory_offset (output_memory_offset),
    .output_count         (output_count),
    .filter_bias          (filter_bias),
    .out_shift            (out_shift),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .in_sum               (in_sum),
    .mem_we               (mem_we),
    .mem_addr             (mem_addr),
    .mem_wdata            (mem_wdata),
    .mem_grant            (mem_grant),
    .wb_done              (wb_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int lastGrantCycle = -1;
  int doneRiseCycle = -1;
  int startCycle = -1;
  int accepts = 0;
  logic prevDone = 1'b0;
  logic [15:0] obsAddr[$];
  logic [15:0] obsData[$];
  logic [31:0] stimSums[$];

  // Passive monitor: records every granted write and handshake on the falling edge.
  always @(negedge clk) begin
    cycle++;
    if (rst === 1'b1) begin
      if (mem_we && mem_grant) begin
        obsAddr.push_back(mem_addr);
        obsData.push_back(mem_wdata);
        lastGrantCycle = cycle;
      end
      if (in_valid && in_ready) accepts++;
      if (start) startCycle = cycle;
      if (wb_done && !prevDone) doneRiseCycle = cycle;
    end
    prevDone = wb_done;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference: widen, bias, arithmetic shift, clamp.
  function automatic logic [15:0] modelResult(input logic [31:0] sum, input int bias, input int shift);
    longint v;
    v = longint'($signed(sum)) + longint'(bias);
    v = v >>> shift;
`ifdef CONV_WB_RELU_EN
    if (v < 0) v = 0;
`else
    if (v < -32768) v = -32768;
`endif
    if (v > 32767) v = 32767;
    return v[15:0];
  endfunction

  task automatic applyStimulus(input logic [15:0] off, input int cnt, input int bias, input int shift,
                               input int grantMode, input int extraValid);
    int waitCnt;
    bit acc;
    obsAddr.delete();
    obsData.delete();
    accepts = 0;
    doneRiseCycle = -1;
    lastGrantCycle = -1;
    output_memory_offset = off;
    output_count = 16'(cnt);
    filter_bias = 18'(bias);
    out_shift = 4'(shift);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    output_memory_offset = 16'($urandom);
    output_count = 16'($urandom);
    filter_bias = 18'($urandom);
    out_shift = 4'($urandom);
    fork
      begin
        for (int i = 0; i < cnt; i++) begin
          in_valid = 1'b1;
          in_sum = stimSums[i];
          waitCnt = 0;
          do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            waitCnt++;
          end while (!acc && waitCnt < 500);
        end
        in_valid = 1'b0;
        if (extraValid != 0) begin
          in_valid = 1'b1;
          in_sum = $urandom;
          repeat (6) @(posedge clk);
          #1;
          in_valid = 1'b0;
        end
      end
      begin
        for (int c = 0; c < 3000 && !wb_done; c++) begin
          if (grantMode == 0) mem_grant = 1'b1;
          else if (grantMode == 1) mem_grant = 1'($urandom_range(0, 1));
          else mem_grant = (c >= 10);
          if (grantMode == 2 && c == 9) begin
            checkOutput("bp_accepts", accepts, 4);
            checkOutput("bp_in_ready", in_ready, 1'b0);
            checkOutput("bp_mem_we", mem_we, 1'b1);
            checkOutput("bp_addr_hold", mem_addr, off);
            checkOutput("bp_no_writes", obsAddr.size(), 0);
          end
          @(posedge clk); #1;
        end
      end
    join
    @(posedge clk); #1;
  endtask

  task automatic checkRun(input string tag, input logic [15:0] off, input int cnt, input int bias, input int shift);
    checkOutput({tag, "_done"}, wb_done, 1'b1);
    checkOutput({tag, "_nwrites"}, obsAddr.size(), cnt);
    checkOutput({tag, "_accepts"}, accepts, cnt);
    for (int i = 0; i < cnt && i < obsAddr.size(); i++) begin
      checkOutput($sformatf("%s_addr%0d", tag, i), obsAddr[i], 16'(off + 16'(i)));
      checkOutput($sformatf("%s_data%0d", tag, i), obsData[i], modelResult(stimSums[i], bias, shift));
    end
    if (cnt > 0) checkOutput({tag, "_done_lat"}, doneRiseCycle, lastGrantCycle + 1);
    else         checkOutput({tag, "_done_lat"}, doneRiseCycle, startCycle + 1);
  endtask

  initial begin
    logic [15:0] off;
    logic [17:0] rb;
    int cnt, bias, shift;

    rst = 1'b0;
    start = 1'b1;
    output_memory_offset = 16'h0;
    output_count = 16'd3;
    filter_bias = '0;
    out_shift = '0;
    in_valid = 1'b0;
    in_sum = '0;
    mem_grant = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("[TB] reset state");
    checkOutput("rst_in_ready", in_ready, 1'b0);
    checkOutput("rst_mem_we", mem_we, 1'b0);
    checkOutput("rst_mem_addr", mem_addr, 16'h0);
    checkOutput("rst_mem_wdata", mem_wdata, 16'h0);
    checkOutput("rst_wb_done", wb_done, 1'b0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("idle_in_ready", in_ready, 1'b0);

    $display("[TB] zero count");
    stimSums.delete();
    applyStimulus(16'h0100, 0, 0, 0, 0, 0);
    checkRun("zero", 16'h0100, 0, 0, 0);

    $display("[TB] basic");
    stimSums = {32'd5, 32'(-50), 32'd1000};
    applyStimulus(16'd2000, 3, 100, 0, 0, 0);
    checkRun("basic", 16'd2000, 3, 100, 0);
    if (obsData.size() == 3) begin
      checkOutput("basic_const0", obsData[0], 16'd105);
      checkOutput("basic_const2", obsData[2], 16'd1100);
    end

    $display("[TB] saturation");
    stimSums = {32'h7FFFFFFF, 32'(-200), 32'h80000000, 32'd32767, 32'(-32768), 32'd32768};
    applyStimulus(16'h0400, 6, 0, 0, 0, 0);
    checkRun("sat", 16'h0400, 6, 0, 0);
    stimSums = {32'h7FFFFFFF, 32'h80000000};
    applyStimulus(16'h0500, 2, 131071, 0, 1, 0);
    checkRun("satbias", 16'h0500, 2, 131071, 0);

    $display("[TB] shift rounding");
    stimSums = {32'(-7)};
    applyStimulus(16'h0600, 1, 0, 1, 0, 0);
    checkRun("shneg", 16'h0600, 1, 0, 1);
    stimSums = {32'd7};
    applyStimulus(16'h0610, 1, 1, 2, 0, 0);
    checkRun("shpos", 16'h0610, 1, 1, 2);

    $display("[TB] backpressure");
    stimSums.delete();
    for (int i = 0; i < 8; i++) stimSums.push_back(32'(int'($urandom_range(0, 40000)) - 20000));
    applyStimulus(16'h3000, 8, -17, 1, 2, 0);
    checkRun("bp", 16'h3000, 8, -17, 1);

    $display("[TB] address wrap and extra valid");
    stimSums = {32'd11, 32'd22, 32'd33};
    applyStimulus(16'hFFFE, 3, 0, 0, 1, 1);
    checkRun("wrap", 16'hFFFE, 3, 0, 0);

    $display("[TB] randomized runs");
    for (int r = 0; r < 5; r++) begin
      off = 16'($urandom);
      cnt = $urandom_range(1, 12);
      rb = 18'($urandom);
      bias = int'($signed(rb));
      shift = $urandom_range(0, 15);
      stimSums.delete();
      for (int i = 0; i < cnt; i++) begin
        if ($urandom_range(0, 3) == 0) stimSums.push_back($urandom);
        else stimSums.push_back(32'(int'($urandom_range(0, 200000)) - 100000));
      end
      applyStimulus(off, cnt, bias, shift, 1, 0);
      checkRun($sformatf("rnd%0d", r), off, cnt, bias, shift);
    end

    $display("[TB] reset mid-run");
    obsAddr.delete();
    obsData.delete();
    output_memory_offset = 16'h1234;
    output_count = 16'd5;
    filter_bias = '0;
    out_shift = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    mem_grant = 1'b1;
    in_valid = 1'b1;
    in_sum = 32'd77;
    for (int c = 0; c < 200 && obsAddr.size() < 2; c++) begin
      @(posedge clk); #1;
    end
    checkOutput("mid_partial", obsAddr.size(), 2);
    rst = 1'b0;
    #1;
    checkOutput("mid_in_ready", in_ready, 1'b0);
    checkOutput("mid_mem_we", mem_we, 1'b0);
    checkOutput("mid_mem_addr", mem_addr, 16'h0);
    checkOutput("mid_mem_wdata", mem_wdata, 16'h0);
    checkOutput("mid_wb_done", wb_done, 1'b0);
    in_valid = 1'b0;
    mem_grant = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    stimSums = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    applyStimulus(16'h1234, 5, 10, 0, 0, 0);
    checkRun("fresh", 16'h1234, 5, 10, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
